// File: rtl/led_soft_fade_if.sv
// Bus between the blink generator side and the LED output stage.
// The master drives the blink request and target level; the slave returns LED drive and status.
interface led_soft_fade_if #(
   parameter int PWM_BITS = 8
);
   logic                led_in;
   logic [PWM_BITS-1:0] brightness;
   logic                led_out;
   logic [PWM_BITS-1:0] level;
   logic                busy;

   modport master (
      output led_in,
      output brightness,
      input  led_out,
      input  level,
      input  busy
   );

   modport slave (
      input  led_in,
      input  brightness,
      output led_out,
      output level,
      output busy
   );
endinterface

// File: rtl/led_soft_fade.sv
// LED soft-fade output stage: ramps a PWM level toward the blink target and
// drives the LED pin with a period-synchronous, glitch-free PWM waveform.
module led_soft_fade #(
   parameter int PWM_BITS = 8,
   parameter int RAMP_DIV = 23_438
) (
   input  logic          clock,
   input  logic          reset_n,
   led_soft_fade_if.slave bus
);

   localparam int RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [RC_W-1:0] RAMP_LAST = RC_W'(RAMP_DIV - 1);

   typedef enum logic [1:0] {
      OFF     = 2'd0,
      RISING  = 2'd1,
      ON      = 2'd2,
      FALLING = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                led_in_q, led_in_d;
   logic [PWM_BITS-1:0] level_q, level_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [RC_W-1:0]     ramp_cnt_q, ramp_cnt_d;
   logic                busy_q, busy_d;
   logic                led_out_q, led_out_d;
   logic [PWM_BITS-1:0] target;
   logic                ramp_tick;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= OFF;
         led_in_q   <= 1'b0;
         level_q    <= '0;
         duty_q     <= '0;
         pwm_cnt_q  <= '0;
         ramp_cnt_q <= '0;
         busy_q     <= 1'b0;
         led_out_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         led_in_q   <= led_in_d;
         level_q    <= level_d;
         duty_q     <= duty_d;
         pwm_cnt_q  <= pwm_cnt_d;
         ramp_cnt_q <= ramp_cnt_d;
         busy_q     <= busy_d;
         led_out_q  <= led_out_d;
      end
   end

   always_comb begin
      led_in_d   = bus.led_in;
      target     = led_in_q ? bus.brightness : '0;
      ramp_tick  = (ramp_cnt_q == RAMP_LAST);
      ramp_cnt_d = ramp_tick ? '0 : ramp_cnt_q + 1'b1;

      if (target > level_q) begin
         state_d = RISING;
      end else if (target < level_q) begin
         state_d = FALLING;
      end else if (level_q != '0) begin
         state_d = ON;
      end else begin
         state_d = OFF;
      end

      // The target guard stops a stale direction from overshooting when the target moves mid-ramp.
      level_d = level_q;
      if (ramp_tick) begin
         if (state_q == RISING && level_q < target) begin
            level_d = level_q + 1'b1;
         end else if (state_q == FALLING && level_q > target) begin
            level_d = level_q - 1'b1;
         end
      end

      busy_d    = (state_d == RISING) || (state_d == FALLING);
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      duty_d    = (pwm_cnt_q == '1) ? level_q : duty_q;
      led_out_d = (pwm_cnt_q < duty_q);
   end

   assign bus.led_out = led_out_q;
   assign bus.level   = level_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_led_soft_fade.sv
// Directed bench for led_soft_fade with a small ramp divider and 4-bit PWM;
// expectations are queued when stimulus is driven and popped as outputs are sampled.
module tb_led_soft_fade;

   localparam int PWM_BITS = 4;
   localparam int RAMP_DIV = 4;

   logic clock;
   logic reset_n;

   led_soft_fade_if #(.PWM_BITS(PWM_BITS)) bus ();

   led_soft_fade #(
      .PWM_BITS(PWM_BITS),
      .RAMP_DIV(RAMP_DIV)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      string       tag;
      logic [31:0] value;
   } exp_t;

   exp_t sbQueue[$];
   int   checkCount;
   int   passCount;
   int   cycles;
   int   highCount;
   bit   ok;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic applyStimulus(input logic ledIn, input logic [PWM_BITS-1:0] bright);
      bus.led_in     = ledIn;
      bus.brightness = bright;
   endtask

   task automatic expectValue(input string tag, input int value);
      exp_t e;
      e.tag   = tag;
      e.value = 32'(value);
      sbQueue.push_back(e);
   endtask

   task automatic checkOutput(input logic [31:0] observed);
      exp_t e;
      checkCount++;
      if (sbQueue.size() == 0) begin
         $error("[TB] FAIL scoreboard_empty observed=%0d expected=none", observed);
         return;
      end
      e = sbQueue.pop_front();
      assert (observed === e.value) passCount++;
      else $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, observed, e.value);
   endtask

   task automatic waitLevel(input int target, input int bound, output int n, output bit reached);
      n = 0;
      while (int'(bus.level) != target && n < bound) begin
         @(negedge clock);
         n++;
      end
      reached = (int'(bus.level) == target);
   endtask

   task automatic countHigh(output int n);
      n = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         if (bus.led_out === 1'b1) n++;
      end
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      reset_n    = 1'b0;
      applyStimulus(1'b1, 4'd15);

      $display("[TB] reset held with led_in=1");
      for (int r = 0; r < 2; r++) begin
         repeat (4) @(negedge clock);
         expectValue("rst_led_out", 0);
         expectValue("rst_level", 0);
         expectValue("rst_busy", 0);
         checkOutput(32'(bus.led_out));
         checkOutput(32'(bus.level));
         checkOutput(32'(bus.busy));
      end

      $display("[TB] ramp up to 15");
      applyStimulus(1'b0, 4'd15);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(negedge clock);
      expectValue("idle_level", 0);
      expectValue("idle_busy", 0);
      checkOutput(32'(bus.level));
      checkOutput(32'(bus.busy));
      applyStimulus(1'b1, 4'd15);
      repeat (2) @(negedge clock);
      expectValue("rise_busy_2clk", 1);
      checkOutput(32'(bus.busy));
      waitLevel(1, 8, cycles, ok);
      expectValue("rise_first_step", 1);
      checkOutput(32'(ok));
      waitLevel(15, 80, cycles, ok);
      expectValue("rise_reach15", 1);
      expectValue("rise_cycles_1_to_15", 56);
      expectValue("busy_at_top", 1);
      checkOutput(32'(ok));
      checkOutput(32'(cycles));
      checkOutput(32'(bus.busy));
      @(negedge clock);
      expectValue("on_busy", 0);
      expectValue("on_level", 15);
      checkOutput(32'(bus.busy));
      checkOutput(32'(bus.level));

      $display("[TB] retarget down to 6");
      applyStimulus(1'b1, 4'd6);
      waitLevel(6, 80, cycles, ok);
      expectValue("retarget_reach6", 1);
      checkOutput(32'(ok));
      repeat (20) @(negedge clock);
      expectValue("retarget_hold6", 6);
      expectValue("retarget_busy", 0);
      checkOutput(32'(bus.level));
      checkOutput(32'(bus.busy));
      repeat (32) @(negedge clock);
      countHigh(highCount);
      expectValue("duty_6", 6);
      checkOutput(32'(highCount));

      $display("[TB] duty at levels 5, 15, 0");
      applyStimulus(1'b1, 4'd5);
      waitLevel(5, 80, cycles, ok);
      expectValue("reach5", 1);
      checkOutput(32'(ok));
      repeat (40) @(negedge clock);
      countHigh(highCount);
      expectValue("duty_5", 5);
      checkOutput(32'(highCount));

      applyStimulus(1'b1, 4'd15);
      waitLevel(15, 80, cycles, ok);
      expectValue("reach15", 1);
      checkOutput(32'(ok));
      repeat (40) @(negedge clock);
      countHigh(highCount);
      expectValue("duty_15", 15);
      checkOutput(32'(highCount));

      applyStimulus(1'b0, 4'd15);
      waitLevel(0, 100, cycles, ok);
      expectValue("reach0", 1);
      checkOutput(32'(ok));
      repeat (40) @(negedge clock);
      countHigh(highCount);
      expectValue("duty_0", 0);
      expectValue("off_busy", 0);
      checkOutput(32'(highCount));
      checkOutput(32'(bus.busy));

      $display("[TB] reverse mid-ramp at level 8");
      applyStimulus(1'b1, 4'd15);
      waitLevel(8, 60, cycles, ok);
      expectValue("rev_reach8", 1);
      checkOutput(32'(ok));
      applyStimulus(1'b0, 4'd15);
      waitLevel(7, 16, cycles, ok);
      expectValue("rev_reach7", 1);
      checkOutput(32'(ok));
      waitLevel(0, 60, cycles, ok);
      expectValue("rev_reach0", 1);
      expectValue("rev_cycles_7_to_0", 28);
      checkOutput(32'(ok));
      checkOutput(32'(cycles));
      @(negedge clock);
      expectValue("rev_off_busy", 0);
      expectValue("rev_off_level", 0);
      checkOutput(32'(bus.busy));
      checkOutput(32'(bus.level));

      $display("[TB] async reset mid-ramp at level 10");
      applyStimulus(1'b1, 4'd15);
      waitLevel(10, 80, cycles, ok);
      expectValue("pre_reset_reach10", 1);
      checkOutput(32'(ok));
      #2 reset_n = 1'b0;
      #1;
      expectValue("async_led_out", 0);
      expectValue("async_level", 0);
      expectValue("async_busy", 0);
      checkOutput(32'(bus.led_out));
      checkOutput(32'(bus.level));
      checkOutput(32'(bus.busy));
      @(negedge clock);
      reset_n = 1'b1;
      expectValue("restart_level0", 0);
      checkOutput(32'(bus.level));
      repeat (2) @(negedge clock);
      expectValue("restart_busy", 1);
      checkOutput(32'(bus.busy));
      waitLevel(1, 8, cycles, ok);
      expectValue("restart_step1", 1);
      checkOutput(32'(ok));

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
